// File: rtl/ripple_counter_n.sv
// Synchronous emulation of a TTL-style presettable up/down counter whose count
// clock is an ordinary input. The count clock is sampled and edge-detected on CLK_DRV.
module ripple_counter_n #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 0,
    parameter bit FALLING = 1
) (
    input  logic             CLK_DRV,
    input  logic             RST,
    input  logic             CNT_CLK,
    input  logic             CLR_N,
    input  logic             LOAD_N,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             DIR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_N,
    output logic             TC,
    output logic             CARRY
);

    localparam int TOP_INT = (MODULUS == 0) ? ((1 << WIDTH) - 1) : (MODULUS - 1);
    localparam logic [WIDTH-1:0] TOP  = TOP_INT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_next;
    logic             edge_q_reg;
    logic             edge_q_next;
    logic             carry_reg;
    logic             carry_next;
    logic             edg;
    logic             wrap;
    logic [WIDTH-1:0] step_val;
    logic             force_zero;

    assign force_zero = RST || !CLR_N;

    always_comb begin
        if (FALLING) begin
            edg = edge_q_reg && !CNT_CLK;
        end else begin
            edg = !edge_q_reg && CNT_CLK;
        end
    end

    // A value above TOP (only reachable by loading) walks on without wrapping
    // until it rolls through the natural 2^WIDTH boundary.
    always_comb begin
        if (DIR) begin
            wrap     = (cnt_reg == TOP);
            step_val = wrap ? ZERO : (cnt_reg + ONE);
        end else begin
            wrap     = (cnt_reg == ZERO);
            step_val = wrap ? TOP : (cnt_reg - ONE);
        end
    end

    always_comb begin
        cnt_next    = cnt_reg;
        edge_q_next = CNT_CLK;
        carry_next  = 1'b0;
        if (force_zero) begin
            cnt_next    = ZERO;
            edge_q_next = 1'b0;
        end else if (!LOAD_N) begin
            cnt_next    = D;
            edge_q_next = 1'b0;
        end else if (edg && EN) begin
            cnt_next   = step_val;
            carry_next = wrap;
        end
    end

    always_ff @(posedge CLK_DRV) begin
        if (RST) begin
            cnt_reg    <= ZERO;
            edge_q_reg <= 1'b0;
            carry_reg  <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            edge_q_reg <= edge_q_next;
            carry_reg  <= carry_next;
        end
    end

    // Clear and load bypass the register so they act with zero latency.
    always_comb begin
        if (force_zero) begin
            Q = ZERO;
        end else if (!LOAD_N) begin
            Q = D;
        end else begin
            Q = cnt_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_qn
            assign Q_N[gi] = ~Q[gi];
        end
    endgenerate

    assign TC    = (DIR && (Q == TOP)) || (!DIR && (Q == ZERO));
    assign CARRY = carry_reg && !RST;

endmodule

// File: tb/tb_ripple_counter_n.sv
// Randomised plus directed bench for ripple_counter_n: a binary and a mod-10 instance
// share stimulus; expected outputs are queued per cycle and checked by a monitor.
module tb_ripple_counter_n;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cnt_clk = 1'b0;
    logic       clr_n = 1'b1;
    logic       load_n = 1'b1;
    logic [3:0] d = 4'd0;
    logic       en = 1'b1;
    logic       dir = 1'b1;
    logic [3:0] q0, qn0, q1, qn1;
    logic       tc0, tc1, carry0, carry1;

    always #5 clk = ~clk;

    ripple_counter_n #(.WIDTH(4), .MODULUS(0), .FALLING(1)) dut_bin (
        .CLK_DRV(clk), .RST(rst), .CNT_CLK(cnt_clk), .CLR_N(clr_n), .LOAD_N(load_n),
        .D(d), .EN(en), .DIR(dir), .Q(q0), .Q_N(qn0), .TC(tc0), .CARRY(carry0)
    );

    ripple_counter_n #(.WIDTH(4), .MODULUS(10), .FALLING(1)) dut_mod (
        .CLK_DRV(clk), .RST(rst), .CNT_CLK(cnt_clk), .CLR_N(clr_n), .LOAD_N(load_n),
        .D(d), .EN(en), .DIR(dir), .Q(q1), .Q_N(qn1), .TC(tc1), .CARRY(carry1)
    );

    typedef struct {
        int q;
        bit tc;
        bit carry;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   passed = 0;
    int   total  = 0;

    // Reference state: the stored count, last sampled count clock, pending carry.
    int   m_cnt[2]   = '{0, 0};
    bit   m_prev[2]  = '{0, 0};
    bit   m_carry[2] = '{0, 0};
    int   tops[2]    = '{15, 9};

    function automatic void chk(string name, int act, int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    endfunction

    // Called once per cycle after inputs settle: queue this cycle's outputs,
    // then advance the reference to what it holds after the next rising edge.
    task automatic model_cycle();
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            int   top = tops[k];
            int   c   = m_cnt[k];
            if (rst || !clr_n)  e.q = 0;
            else if (!load_n)   e.q = int'(d);
            else                e.q = c;
            e.tc    = dir ? (e.q == top) : (e.q == 0);
            e.carry = rst ? 1'b0 : m_carry[k];
            if (k == 0) sb0.push_back(e);
            else        sb1.push_back(e);

            if (rst || !clr_n) begin
                m_cnt[k] = 0; m_prev[k] = 0; m_carry[k] = 0;
            end else if (!load_n) begin
                m_cnt[k] = int'(d); m_prev[k] = 0; m_carry[k] = 0;
            end else begin
                bit fell = m_prev[k] && !cnt_clk;
                m_prev[k]  = cnt_clk;
                m_carry[k] = 0;
                if (fell && en) begin
                    if (dir) begin
                        m_carry[k] = (c == top);
                        m_cnt[k]   = (c == top) ? 0 : (c + 1) % 16;
                    end else begin
                        m_carry[k] = (c == 0);
                        m_cnt[k]   = (c == 0) ? top : c - 1;
                    end
                end
            end
        end
    endtask

    task automatic drive(bit r, bit cc, bit cl, bit ld, int dv, bit e_, bit dr);
        @(posedge clk);
        #1;
        rst = r; cnt_clk = cc; clr_n = cl; load_n = ld; d = 4'(dv); en = e_; dir = dr;
        model_cycle();
    endtask

    task automatic edges(int n, bit e_, bit dr);
        repeat (n) begin
            drive(0, 1, 1, 1, 0, e_, dr);
            drive(0, 0, 1, 1, 0, e_, dr);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb0.size() > 0) begin
            e = sb0.pop_front();
            chk("bin_q", int'(q0), e.q);
            chk("bin_qn", int'(qn0), (~e.q) & 15);
            chk("bin_tc", int'(tc0), int'(e.tc));
            chk("bin_carry", int'(carry0), int'(e.carry));
        end
        if (sb1.size() > 0) begin
            e = sb1.pop_front();
            chk("mod_q", int'(q1), e.q);
            chk("mod_qn", int'(qn1), (~e.q) & 15);
            chk("mod_tc", int'(tc1), int'(e.tc));
            chk("mod_carry", int'(carry1), int'(e.carry));
        end
    end

    initial begin
        bit rdir = 1'b1;
        repeat (3) drive(1, 0, 1, 1, 0, 1, 1);
        // Full binary up count: 16 edges wrap 15->0 with one carry.
        edges(16, 1, 1);
        drive(0, 0, 1, 1, 0, 1, 1);
        // Mod-10 up count, then load 12 and count past the top.
        drive(0, 0, 0, 1, 0, 1, 1);
        edges(10, 1, 1);
        drive(0, 0, 1, 0, 12, 1, 1);
        edges(4, 1, 1);
        drive(0, 0, 1, 1, 0, 1, 1);
        // Down count from zero wraps to top.
        drive(0, 0, 0, 1, 0, 1, 0);
        edges(2, 1, 0);
        drive(0, 0, 1, 1, 0, 1, 0);
        // Clear with count clock held low: no phantom edge after release.
        repeat (3) drive(0, 0, 0, 1, 0, 1, 1);
        repeat (3) drive(0, 0, 1, 1, 0, 1, 1);
        edges(1, 1, 1);
        drive(0, 0, 1, 1, 0, 1, 1);
        // Disabled edges, then re-enable with clock steady low.
        edges(5, 0, 1);
        repeat (4) drive(0, 0, 1, 1, 0, 1, 1);
        // Reset coincident with an edge at Q=7.
        drive(0, 0, 0, 1, 0, 1, 1);
        edges(7, 1, 1);
        drive(0, 1, 1, 1, 0, 1, 1);
        drive(1, 0, 1, 1, 0, 1, 1);
        repeat (2) drive(0, 0, 1, 1, 0, 1, 1);
        // Load coincident with an edge: the load wins.
        drive(0, 1, 1, 1, 0, 1, 1);
        drive(0, 0, 1, 0, 5, 1, 1);
        repeat (2) drive(0, 0, 1, 1, 0, 1, 1);
        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) rdir = ~rdir;
            drive($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 39) != 0, $urandom_range(0, 24) != 0,
                  int'($urandom_range(0, 15)), $urandom_range(0, 3) != 0, rdir);
        end
        drive(0, 0, 1, 1, 0, 1, 1);
        for (int i = 0; i < 10 && (sb0.size() > 0 || sb1.size() > 0); i++) @(negedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", sb0.size() + sb1.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule
